// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider:
// FSM state encoding, default widths and the divide-by-zero quotient.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = 4;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, and keep the difference only if it did not borrow.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The extra top bit only carries the borrow; the restored remainder
  // is always below the divisor, so it fits back into WIDTH bits.
  always_comb begin
    shifted = {r, q_msb};
    trial   = shifted - {1'b0, d};
    q_bit   = ~trial[WIDTH];
    r_next  = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake;
// one quotient bit per clock, divide-by-zero answered immediately.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t state, state_next;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;
  logic             last_iter;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_reg),
    .q_msb  (q_reg[WIDTH-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:  if (last_iter) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operands are captured only on an accepted start, results
  // are written only on completion and otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
              quotient    <= DBZ_QUOTIENT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= {q_reg[WIDTH-2:0], q_bit};
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            quotient    <= {q_reg[WIDTH-2:0], q_bit};
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
